// File: rtl/dpi_stream.sv
`default_nettype none
// ============================================================================
// Module   : dpi_stream (with host-link package dpi_comm_pkg)
// Purpose  : Moves DATA_W-bit words between RTL valid/ready streams and a
//            host socket. Each word travels as ceil(DATA_W/64) little-endian
//            64-bit beats. TX and RX FIFOs absorb host backpressure, and
//            refused TX beats are retried every cycle.
// Ports    : clk          - single clock, rising edge
//            reset        - synchronous, active-high
//            tx_data/tx_valid/tx_ready - word stream towards the host
//            rx_data/rx_valid/rx_ready - word stream from the host (FIFO head)
//            tx_level     - TX FIFO occupancy (registered, post-edge)
//            rx_level     - RX FIFO occupancy (registered, post-edge)
//            tx_stall_cnt - saturating count of TX beats the host refused
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Host-link entry points. This SystemVerilog body stands in for the
// socket library. It keeps the same call signatures, so the block elaborates
// and simulates without a foreign-language object. The host side is driven
// through the package state: refusal control, outgoing and incoming beat
// queues, and call counters.
// ----------------------------------------------------------------------------
package dpi_comm_pkg;
    int          next_id;
    string       conn_name;
    int          conn_port;
    bit          conn_wait;
    int          rx_last_blocking;

    int unsigned tx_refuse;      // refuse this many upcoming TX calls
    bit          tx_block;       // refuse every TX call while set
    int unsigned tx_calls;
    int unsigned rx_calls;
    int unsigned rx_hits;
    logic [63:0] tx_call_log[$]; // every beat offered, accepted or not
    logic [63:0] tx_acc[$];      // beats the host accepted
    logic [63:0] rx_src[$];      // beats the host has waiting for the RTL

    function automatic int dpi_comm_init(input string name, input int port,
                                         input bit wait_for_connection);
        conn_name = name;
        conn_port = port;
        conn_wait = wait_for_connection;
        next_id++;
        return next_id;
    endfunction

    function automatic bit dpi_comm_tx(input int id, input logic [63:0] beat);
        tx_calls++;
        tx_call_log.push_back(beat);
        if (id <= 0) return 1'b0;
        if (tx_refuse != 0) begin
            tx_refuse--;
            return 1'b0;
        end
        if (tx_block) return 1'b0;
        tx_acc.push_back(beat);
        return 1'b1;
    endfunction

    function automatic bit dpi_comm_rx(input int id, input int blocking,
                                       output logic [63:0] beat);
        rx_calls++;
        rx_last_blocking = blocking;
        beat = '0;
        if (id <= 0 || rx_src.size() == 0) return 1'b0;
        beat = rx_src.pop_front();
        rx_hits++;
        return 1'b1;
    endfunction
endpackage

module dpi_stream #(
    parameter string name                = "dpi_stream",
    parameter int    port                = 7337,
    parameter bit    wait_for_connection = 1'b1,
    parameter int    DATA_W              = 64,
    parameter int    TX_DEPTH            = 4,
    parameter int    RX_DEPTH            = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic [31:0]               tx_stall_cnt
);
    import dpi_comm_pkg::*;

    localparam int c_beats  = (DATA_W + 63) / 64;
    localparam int c_wide_w = c_beats * 64;
    localparam int c_idx_w  = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_tx_aw  = $clog2(TX_DEPTH);
    localparam int c_rx_aw  = $clog2(RX_DEPTH);
    localparam int c_tx_lw  = c_tx_aw + 1;
    localparam int c_rx_lw  = c_rx_aw + 1;

    localparam logic [c_idx_w-1:0] c_last_beat = c_idx_w'(c_beats - 1);
    localparam logic [c_tx_lw-1:0] c_tx_full   = c_tx_lw'(TX_DEPTH);
    localparam logic [c_rx_lw-1:0] c_rx_full   = c_rx_lw'(RX_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } tx_state_t;

    // Connection handle: obtained once at start-up, deliberately untouched
    // by reset so the host link outlives any number of RTL resets.
    int r_id;
    initial r_id = dpi_comm_init(name, port, wait_for_connection);

    // ------------------------------------------------------------------
    // Reset shadow: keeps tx_ready low for the edge that ends reset.
    // ------------------------------------------------------------------
    logic r_rst_q;

    always_ff @(posedge clk) begin
        r_rst_q <= reset;
    end

    // ------------------------------------------------------------------
    // TX FIFO and beat engine
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_tx_mem [TX_DEPTH];
    logic [c_tx_aw-1:0]  r_tx_wr;
    logic [c_tx_aw-1:0]  r_tx_rd;
    logic [c_tx_lw-1:0]  r_tx_level;
    logic [c_idx_w-1:0]  r_tb;
    logic [31:0]         r_tx_stall;
    tx_state_t           r_tx_state;

    logic                w_tx_push;
    logic [c_wide_w-1:0] w_tx_wide;
    logic [63:0]         w_tx_beat;
    logic [c_tx_lw-1:0]  w_tx_level_hold;
    logic [c_tx_lw-1:0]  w_tx_level_pop;
    tx_state_t           w_tx_state_hold;
    tx_state_t           w_tx_state_pop;

    assign tx_ready     = !r_rst_q && (r_tx_level != c_tx_full);
    assign w_tx_push    = tx_valid && tx_ready;
    assign tx_level     = r_tx_level;
    assign tx_stall_cnt = r_tx_stall;

    // Zero-extension supplies the zero padding above DATA_W in the last beat.
    assign w_tx_wide = c_wide_w'(r_tx_mem[r_tx_rd]);
    assign w_tx_beat = w_tx_wide[64*int'(r_tb) +: 64];

    // The host's answer is only known inside the clocked call. The next
    // state and level are therefore computed here for both outcomes: head
    // word retired (pop) or not (hold). SEND is entered or kept whenever the
    // post-edge FIFO is non-empty. A word pushed into an empty FIFO is
    // therefore offered on the very next edge.
    always_comb begin
        w_tx_level_hold = r_tx_level + c_tx_lw'(w_tx_push);
        w_tx_level_pop  = w_tx_level_hold - c_tx_lw'(1);
        w_tx_state_hold = (w_tx_level_hold != '0) ? S_SEND : S_IDLE;
        w_tx_state_pop  = (w_tx_level_pop  != '0) ? S_SEND : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= S_IDLE;
            r_tb       <= '0;
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_level <= '0;
            r_tx_stall <= '0;
        end else begin
            r_tx_level <= w_tx_level_hold;
            r_tx_state <= w_tx_state_hold;
            if (w_tx_push) begin
                r_tx_mem[r_tx_wr] <= tx_data;
                r_tx_wr           <= r_tx_wr + c_tx_aw'(1);
            end
            if (r_tx_state == S_SEND) begin
                if (dpi_comm_tx(r_id, w_tx_beat)) begin
                    if (r_tb == c_last_beat) begin
                        r_tb       <= '0;
                        r_tx_rd    <= r_tx_rd + c_tx_aw'(1);
                        r_tx_level <= w_tx_level_pop;
                        r_tx_state <= w_tx_state_pop;
                    end else begin
                        r_tb <= r_tb + c_idx_w'(1);
                    end
                end else if (r_tx_stall != '1) begin
                    // Refused: head word and beat index stay put for a retry.
                    r_tx_stall <= r_tx_stall + 32'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // RX assembler and FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_rx_mem [RX_DEPTH];
    logic [c_rx_aw-1:0]  r_rx_wr;
    logic [c_rx_aw-1:0]  r_rx_rd;
    logic [c_rx_lw-1:0]  r_rx_level;
    logic [c_idx_w-1:0]  r_rb;
    logic [c_wide_w-1:0] r_rx_asm;

    logic                w_rx_pop;
    logic                w_rx_space;
    logic [c_rx_lw-1:0]  w_rx_level_pop;
    logic [c_rx_lw-1:0]  w_rx_level_push;

    assign rx_valid = (r_rx_level != '0);
    assign rx_data  = rx_valid ? r_rx_mem[r_rx_rd] : '0;
    assign rx_level = r_rx_level;
    assign w_rx_pop = rx_valid && rx_ready;

    // Space is judged on the pre-edge level only. A pop on the same edge
    // does not free a slot for that edge's call.
    always_comb begin
        w_rx_space      = (r_rx_level < c_rx_full);
        w_rx_level_pop  = r_rx_level - c_rx_lw'(w_rx_pop);
        w_rx_level_push = w_rx_level_pop + c_rx_lw'(1);
    end

    // Merge the final beat into the collected lower beats. Bits of the last
    // beat above DATA_W are dropped.
    function automatic logic [DATA_W-1:0] assemble_word(
        input logic [c_wide_w-1:0] partial,
        input logic [63:0]         last_beat
    );
        logic [c_wide_w-1:0] v_word;
        v_word = partial;
        v_word[c_wide_w-1 -: 64] = last_beat;
        return v_word[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk) begin : p_rx_engine
        logic [63:0] v_beat;
        if (reset) begin
            r_rb       <= '0;
            r_rx_asm   <= '0;
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_level <= '0;
        end else begin
            r_rx_level <= w_rx_level_pop;
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + c_rx_aw'(1);
            end
            // No call at all when full, so the host keeps its pending beat.
            if (w_rx_space) begin
                if (dpi_comm_rx(r_id, 1, v_beat)) begin
                    if (r_rb == c_last_beat) begin
                        r_rx_mem[r_rx_wr] <= assemble_word(r_rx_asm, v_beat);
                        r_rx_wr           <= r_rx_wr + c_rx_aw'(1);
                        r_rx_level        <= w_rx_level_push;
                        r_rb              <= '0;
                    end else begin
                        r_rx_asm[64*int'(r_rb) +: 64] <= v_beat;
                        r_rb                          <= r_rb + c_idx_w'(1);
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
